// File: rtl/udp_tx_scheduler.sv
// Round-robin transmit scheduler: shares one UDP/IP/MAC path among NUM_CH packet
// sources, resolving ARP, streaming payload bytes and enforcing the inter-frame gap.
module udp_tx_scheduler #(
    parameter int NUM_CH      = 2,
    parameter int MAX_LEN     = 1472,
    parameter int ARP_TIMEOUT = 125_000_000,
    parameter int ARP_RETRY   = 3,
    parameter int IFG_CYCLES  = 12
) (
    input  logic                 rgmii_clk,
    input  logic                 rstn,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [16*NUM_CH-1:0] ch_len,
    input  logic [8*NUM_CH-1:0]  ch_data,
    output logic [NUM_CH-1:0]    ch_rd,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [NUM_CH-1:0]    ch_drop,
    output logic                 app_data_request,
    output logic [15:0]          app_data_length,
    input  logic                 udp_send_ack,
    output logic                 app_data_in_valid,
    output logic [7:0]           app_data_in,
    output logic                 arp_req,
    input  logic                 arp_found,
    input  logic                 mac_not_exist,
    input  logic                 mac_send_end,
    output logic                 busy
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [3:0] {
        IDLE, ARB, CHECK, ARP_REQ, ARP_SEND, ARP_WAIT, GEN_REQ, STREAM, SEND_WAIT, GAP
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, gnt_idx, sel_idx;
    logic              sel_found;
    logic [15:0]       sel_len;
    logic [7:0]        gnt_data;
    logic [31:0]       tmo_cnt;
    logic [7:0]        retry_cnt;
    logic [15:0]       byte_cnt;
    logic [15:0]       gap_cnt;
    logic              len_bad, arp_tmo, retry_left, last_byte;
    logic [15:0]       len_arr  [NUM_CH];
    logic [7:0]        data_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign len_arr[g]  = ch_len[16*g +: 16];
        assign data_arr[g] = ch_data[8*g +: 8];
    end

    // Search starts just after the last granted channel and wraps around.
    always_comb begin
        logic [IDX_W-1:0] c;
        c         = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (rr_ptr >= IDX_W'(NUM_CH - k)) ? rr_ptr - IDX_W'(NUM_CH - k)
                                               : rr_ptr + IDX_W'(k);
            if (!sel_found && ch_req[c]) begin
                sel_found = 1'b1;
                sel_idx   = c;
            end
        end
    end

    assign sel_len    = len_arr[sel_idx];
    assign gnt_data   = data_arr[gnt_idx];
    assign len_bad    = (sel_len == 16'd0) || (sel_len > 16'(MAX_LEN));
    assign arp_tmo    = (tmo_cnt == 32'(ARP_TIMEOUT - 1));
    assign retry_left = (retry_cnt < 8'(ARP_RETRY));
    assign last_byte  = (byte_cnt == app_data_length - 16'd1);

    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        arp_req          = 1'b0;
        app_data_request = 1'b0;
        ch_rd            = '0;
        busy             = (state != IDLE);
        case (state)
            IDLE:      if (|ch_req) state_nxt = ARB;
            ARB: begin
                if (!sel_found)  state_nxt = IDLE;
                else if (len_bad) state_nxt = GAP;
                else              state_nxt = CHECK;
            end
            CHECK:     state_nxt = mac_not_exist ? ARP_REQ : GEN_REQ;
            ARP_REQ: begin
                arp_req   = 1'b1;
                state_nxt = ARP_SEND;
            end
            ARP_SEND:  if (mac_send_end) state_nxt = ARP_WAIT;
            ARP_WAIT: begin
                if (arp_found)    state_nxt = GEN_REQ;
                else if (arp_tmo) state_nxt = retry_left ? ARP_REQ : GAP;
            end
            GEN_REQ: begin
                app_data_request = 1'b1;
                if (udp_send_ack) state_nxt = STREAM;
            end
            STREAM: begin
                ch_rd = ch_grant;
                if (last_byte) state_nxt = SEND_WAIT;
            end
            SEND_WAIT: if (mac_send_end) state_nxt = GAP;
            GAP:       if (gap_cnt == 16'(IFG_CYCLES - 1)) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr            <= IDX_W'(NUM_CH - 1);
            gnt_idx           <= '0;
            ch_grant          <= '0;
            ch_done           <= '0;
            ch_drop           <= '0;
            app_data_length   <= '0;
            app_data_in_valid <= 1'b0;
            app_data_in       <= '0;
            tmo_cnt           <= '0;
            retry_cnt         <= '0;
            byte_cnt          <= '0;
            gap_cnt           <= '0;
        end else begin
            ch_done           <= '0;
            ch_drop           <= '0;
            app_data_in_valid <= 1'b0;
            gap_cnt           <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
            case (state)
                ARB: if (sel_found) begin
                    gnt_idx         <= sel_idx;
                    rr_ptr          <= sel_idx;
                    app_data_length <= sel_len;
                    retry_cnt       <= '0;
                    // A rejected packet never holds the grant; only the drop pulse shows.
                    if (len_bad) ch_drop  <= NUM_CH'(1) << sel_idx;
                    else         ch_grant <= NUM_CH'(1) << sel_idx;
                end
                ARP_REQ:  retry_cnt <= retry_cnt + 8'd1;
                ARP_SEND: tmo_cnt   <= '0;
                ARP_WAIT: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (!arp_found && arp_tmo && !retry_left) begin
                        ch_drop  <= ch_grant;
                        ch_grant <= '0;
                    end
                end
                GEN_REQ:  byte_cnt <= '0;
                STREAM: begin
                    app_data_in       <= gnt_data;
                    app_data_in_valid <= 1'b1;
                    byte_cnt          <= byte_cnt + 16'd1;
                end
                SEND_WAIT: if (mac_send_end) begin
                    ch_done  <= ch_grant;
                    ch_grant <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
